// File: rtl/fifo_frame_pkg.sv
// rtl/fifo_frame_pkg.sv - shared state encoding and defaults for the frame reader
package fifo_frame_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_CSUM    = 2'd2
    } frame_state_e;

    localparam int         DEF_FRAME_LEN = 4;
    localparam logic [7:0] DEF_HDR_BYTE  = 8'hA5;

endpackage

// File: rtl/frame_skid_buf.sv
// rtl/frame_skid_buf.sv - 2-entry data+last output buffer, head always in entry 0
module frame_skid_buf (
    input  logic       clk,
    input  logic       rst,
    input  logic       push_i,
    input  logic [7:0] push_data_i,
    input  logic       push_last_i,
    input  logic       pop_i,
    output logic [1:0] count_o,
    output logic [7:0] head_data_o,
    output logic       head_last_o
);

    logic [8:0] ent0_q, ent0_d;
    logic [8:0] ent1_q, ent1_d;
    logic [1:0] count_q, count_d;
    logic       pop_eff;
    logic       push_eff;

    // Shift-register buffer: pops move entry 1 down; a push while full is only taken with a pop
    always_comb begin
        ent0_d   = ent0_q;
        ent1_d   = ent1_q;
        count_d  = count_q;
        pop_eff  = pop_i && (count_q != 2'd0);
        push_eff = push_i && ((count_q != 2'd2) || pop_eff);
        case ({push_eff, pop_eff})
            2'b10: begin
                if (count_q == 2'd0) ent0_d = {push_last_i, push_data_i};
                else                 ent1_d = {push_last_i, push_data_i};
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                ent0_d  = ent1_q;
                count_d = count_q - 2'd1;
            end
            2'b11: begin
                if (count_q == 2'd1) begin
                    ent0_d = {push_last_i, push_data_i};
                end else begin
                    ent0_d = ent1_q;
                    ent1_d = {push_last_i, push_data_i};
                end
            end
            default: ;
        endcase
    end

    // Buffer storage and occupancy registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ent0_q  <= '0;
            ent1_q  <= '0;
            count_q <= '0;
        end else begin
            ent0_q  <= ent0_d;
            ent1_q  <= ent1_d;
            count_q <= count_d;
        end
    end

    assign count_o     = count_q;
    assign head_data_o = ent0_q[7:0];
    assign head_last_o = ent0_q[8];

endmodule

// File: rtl/fifo_frame_reader.sv
// rtl/fifo_frame_reader.sv - pulls bytes from a FIFO and emits header/payload/checksum frames
module fifo_frame_reader
    import fifo_frame_pkg::*;
#(
    parameter int         FRAME_LEN = DEF_FRAME_LEN,
    parameter logic [7:0] HDR_BYTE  = DEF_HDR_BYTE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fifo_empty,
    input  logic [7:0]  fifo_data,
    output logic        fifo_rd,
    output logic        m_valid,
    output logic [7:0]  m_data,
    output logic        m_last,
    input  logic        m_ready,
    output logic [15:0] frame_cnt,
    output logic        busy
);

    localparam logic [4:0] LEN5 = 5'(FRAME_LEN);

    frame_state_e state_q, state_d;
    logic [7:0]   csum_q, csum_d;
    logic [4:0]   req_q, req_d;
    logic [4:0]   rcv_q, rcv_d;
    logic         inflight_q;
    logic [15:0]  frame_cnt_q;

    logic       buf_push;
    logic [7:0] buf_push_data;
    logic       buf_push_last;
    logic       buf_pop;
    logic [1:0] buf_count;
    logic [1:0] occ_after_pop;
    logic [1:0] occ_proj;
    logic       slot_free;

    frame_skid_buf u_buf (
        .clk         (clk),
        .rst         (rst),
        .push_i      (buf_push),
        .push_data_i (buf_push_data),
        .push_last_i (buf_push_last),
        .pop_i       (buf_pop),
        .count_o     (buf_count),
        .head_data_o (m_data),
        .head_last_o (m_last)
    );

    assign m_valid       = (buf_count != 2'd0);
    assign buf_pop       = m_valid && m_ready;
    assign occ_after_pop = buf_count - {1'b0, buf_pop};
    assign slot_free     = (occ_after_pop != 2'd2);
    // A read issued now lands next cycle; it must find a slot without counting on a future pop
    assign occ_proj      = occ_after_pop + {1'b0, inflight_q};

    // Next-state, FIFO read request and buffer push selection
    always_comb begin
        state_d       = state_q;
        csum_d        = csum_q;
        req_d         = req_q;
        rcv_d         = rcv_q;
        fifo_rd       = 1'b0;
        buf_push      = 1'b0;
        buf_push_data = 8'h00;
        buf_push_last = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty && slot_free) begin
                    buf_push      = 1'b1;
                    buf_push_data = HDR_BYTE;
                    csum_d        = 8'h00;
                    req_d         = 5'd0;
                    rcv_d         = 5'd0;
                    state_d       = ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                if (inflight_q) begin
                    buf_push      = 1'b1;
                    buf_push_data = fifo_data;
                    csum_d        = csum_q + fifo_data;
                    rcv_d         = rcv_q + 5'd1;
                end
                if (!fifo_empty && (req_q < LEN5) && (occ_proj < 2'd2)) begin
                    fifo_rd = 1'b1;
                    req_d   = req_q + 5'd1;
                end
                if (rcv_d == LEN5) state_d = ST_CSUM;
            end
            ST_CSUM: begin
                if (slot_free) begin
                    buf_push      = 1'b1;
                    buf_push_data = csum_q;
                    buf_push_last = 1'b1;
                    state_d       = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Frame state, checksum, counters and the one-deep read-in-flight flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            csum_q     <= '0;
            req_q      <= '0;
            rcv_q      <= '0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            csum_q     <= csum_d;
            req_q      <= req_d;
            rcv_q      <= rcv_d;
            inflight_q <= fifo_rd;
        end
    end

    // Completed-frame counter bumps when the checksum byte is accepted
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                        frame_cnt_q <= '0;
        else if (buf_pop && m_last)     frame_cnt_q <= frame_cnt_q + 16'd1;
    end

    assign frame_cnt = frame_cnt_q;
    assign busy      = (state_q != ST_IDLE) || (buf_count != 2'd0);

endmodule
